sync_fifo_wr_arb: RTL and testbench
===================================

# sync_fifo_wr_arb

Round-robin write arbiter that shares one `sync_fifo` write port among `NUM_REQ` producers. Each producer presents a valid/data pair. The arbiter grants one producer at a time for a bounded burst and drives `fifo_wren`/`fifo_wrdata` directly. It never writes while `fifo_full` is high, and it guarantees every requester service within a bounded number of cycles.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8
- `FIFO_WIDTH`, 8: data width, equal to the FIFO's `FIFO_WIDTH`
- `MAX_BURST`, 4: maximum beats per grant, at least 1
- `OWNER_W`, `$clog2(NUM_REQ)`: owner index width (localparam)
- `fifo_clk`  in  1  clock
- `fifo_rstb`  in  1  reset, asynchronous, active-low
- `wr_req`  in  NUM_REQ  producer i has a beat valid
- `wr_data`  in  NUM_REQ*FIFO_WIDTH  producer i data in bits [i*FIFO_WIDTH +: FIFO_WIDTH]
- `wr_ack`  out  NUM_REQ  one-hot; beat of producer i accepted this cycle
- `fifo_full`  in  1  from sync_fifo, registered
- `fifo_wren`  out  1  to sync_fifo
- `fifo_wrdata`  out  FIFO_WIDTH  to sync_fifo
- `arb_busy`  out  1  high while in BURST
- `arb_owner`  out  OWNER_W  current or last granted producer

## Operation
- FSM states are IDLE and BURST.
- Registers: `state`, `owner` (OWNER_W), `last_owner` (OWNER_W), `beat_cnt` ($clog2(MAX_BURST)+1 bits).
- IDLE:
  - If `|wr_req`, select the first requester searching upward from `last_owner+1`, wrapping modulo NUM_REQ.
  - Load `owner` and `last_owner` with it, clear `beat_cnt`, go to BURST.
  - No write occurs in IDLE.
- BURST, accept condition: `accept = wr_req[owner] & ~fifo_full`, combinational.
- BURST outputs:
  - `fifo_wren = accept`
  - `wr_ack[owner] = accept`, all other ack bits 0
  - `fifo_wrdata = wr_data[owner]` (driven regardless of accept)
- On accept, `beat_cnt` increments.
- BURST exits to IDLE in any of these cases:
  - `wr_req[owner]` low, in which case that cycle performs no write.
  - accept with `beat_cnt == MAX_BURST-1`.
- If `fifo_full` is high while `wr_req[owner]` is high, stay in BURST and stall. The grant is held and `beat_cnt` does not advance.
- Producer rules:
  - A producer holds `wr_data` stable while `wr_req` is high and no ack has been given.
  - A producer may drop `wr_req` at any time; the grant is released the same cycle.
- Starvation bound: a continuously requesting producer is granted within (NUM_REQ-1)*(MAX_BURST+1) cycles of FIFO-non-full time.
- Outside BURST, `fifo_wren = 0` and `wr_ack = 0`.
- A read in the same cycle as `fifo_full` high does not unblock the write. The stall lasts one extra cycle until `fifo_full` deasserts.

## Timing
- Reset values:
  - `state` = IDLE
  - `owner` = 0
  - `last_owner` = NUM_REQ-1, so producer 0 wins first
  - `beat_cnt` = 0
  - `fifo_wren` = 0
  - `wr_ack` = 0
  - `arb_busy` = 0
  - `arb_owner` = 0
  - `fifo_wrdata` follows `wr_data[0]`
- Arbitration latency: a request seen in IDLE at edge N gives its first possible accept in cycle N+1.
- A burst end costs exactly one IDLE bubble cycle before the next grant.
- Accept-to-FIFO: the write occurs on the same edge as `wr_ack`. The sync_fifo updates `fifo_full` on that edge, so a write is never issued into a full FIFO.
- Reset mid-burst: all state clears asynchronously. The in-flight beat not acked before reset is lost and the producer must re-present it.
- `arb_busy` and `arb_owner` are registered. `wr_ack`, `fifo_wren` and `fifo_wrdata` are combinational from registers, `wr_req`, `wr_data` and `fifo_full`.

## Structure
- Shared package `sync_fifo_pkg`:
  - state encoding (IDLE=1'b0, BURST=1'b1)
  - the default widths FIFO_WIDTH=8, FIFO_PTR=4, FIFO_DEPTH=16 used across the FIFO family
- One sub-module `rr_pick`: combinational round-robin selector taking `wr_req` and `last_owner` and returning `owner_nxt` plus `any_req`. It is reusable for a future read-side scheduler.
- Top-level `sync_fifo_wr_arb` holds the FSM, the counters and the output mux.
- The bench instantiates `sync_fifo_wr_arb` together with `sync_fifo` (FIFO_PTR=4, FIFO_DEPTH=16).

## Test plan
- After reset, hold `wr_req=4'b0000` -> outputs at reset values; `fifo_wren` never asserts.
- `wr_req=4'b1111`, each producer sends 0xA0+i continuously, MAX_BURST=4, reads always on -> FIFO receives 4 beats of producer 0, bubble, 4 of producer 1, then 2, then 3. Order is preserved and `wr_ack` is one-hot.
- Producer 2 alone, no reads, 20 beats -> 16 written; `fifo_full` rises after beat 16; `wr_ack` stays low with the grant held; after one read, exactly one more beat is accepted.
- Producer 1 drops `wr_req` after 2 beats of its burst -> that cycle returns to IDLE with no write; `last_owner=1`; the next grant goes to producer 2 even if producer 0 is requesting.
- `fifo_rstb` pulsed low mid-burst after 2 beats -> all outputs return to reset values immediately; the next grant after release goes to producer 0.
- Random requests and random reads over 10k cycles -> scoreboard per producer shows no loss, no duplication and no write while full; the worst-case grant wait is at most 15 cycles.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared state encoding and default widths for the sync_fifo family
package sync_fifo_pkg;
    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} arb_state_e;
    localparam int FIFO_WIDTH = 8;
    localparam int FIFO_PTR   = 4;
    localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/sync_fifo_wr_arb_rr_pick.sv
// rr_pick: combinational round-robin selector, nearest requester above last_owner wins
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int OWNER_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] wr_req,
    input  logic [OWNER_W-1:0] last_owner,
    output logic [OWNER_W-1:0] owner_nxt,
    output logic               any_req
);
    logic [OWNER_W-1:0] idx;
    always_comb begin
        owner_nxt = last_owner;
        idx = '0;
        // scan farthest to nearest so the nearest requester is the final winner
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = OWNER_W'((int'(last_owner) + k) % NUM_REQ);
            if (wr_req[idx]) owner_nxt = idx;
        end
    end
    assign any_req = |wr_req;
endmodule

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin arbiter sharing one sync_fifo write port among
// NUM_REQ producers, granting bounded bursts and never writing into a full FIFO
module sync_fifo_wr_arb #(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_WIDTH = sync_fifo_pkg::FIFO_WIDTH,
    parameter  int MAX_BURST  = 4,
    localparam int OWNER_W    = $clog2(NUM_REQ)
) (
    input  logic                          fifo_clk,
    input  logic                          fifo_rstb,
    input  logic [NUM_REQ-1:0]            wr_req,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]            wr_ack,
    input  logic                          fifo_full,
    output logic                          fifo_wren,
    output logic [FIFO_WIDTH-1:0]         fifo_wrdata,
    output logic                          arb_busy,
    output logic [OWNER_W-1:0]            arb_owner
);
    import sync_fifo_pkg::*;
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    arb_state_e            state, state_nxt;
    logic [OWNER_W-1:0]    owner, owner_nxt, last_owner, last_owner_nxt, pick;
    logic [CNT_W-1:0]      beat_cnt, beat_cnt_nxt;
    logic                  any_req, grant, accept, burst_end;
    logic [FIFO_WIDTH-1:0] lane [NUM_REQ];

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .wr_req    (wr_req),
        .last_owner(last_owner),
        .owner_nxt (pick),
        .any_req   (any_req)
    );

    always_ff @(posedge fifo_clk or negedge fifo_rstb) begin
        if (!fifo_rstb) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OWNER_W'(NUM_REQ - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            last_owner <= last_owner_nxt;
            beat_cnt   <= beat_cnt_nxt;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) lane[k] = wr_data[k*FIFO_WIDTH +: FIFO_WIDTH];
        grant          = (state == IDLE) && any_req;
        accept         = (state == BURST) && wr_req[owner] && !fifo_full;
        // a dropped request or the final beat of the burst releases the grant
        burst_end      = (state == BURST) && (!wr_req[owner] || (accept && beat_cnt == CNT_W'(MAX_BURST - 1)));
        state_nxt      = grant ? BURST : burst_end ? IDLE : state;
        owner_nxt      = grant ? pick : owner;
        last_owner_nxt = grant ? pick : last_owner;
        beat_cnt_nxt   = grant ? '0 : accept ? beat_cnt + 1'b1 : beat_cnt;
        wr_ack         = '0;
        wr_ack[owner]  = accept;
        fifo_wren      = accept;
        fifo_wrdata    = lane[owner];
    end

    assign arb_busy  = (state == BURST);
    assign arb_owner = owner;
endmodule

// File: tb/tb_sync_fifo_wr_arb.sv
// tb_sync_fifo_wr_arb: scoreboard bench for sync_fifo_wr_arb driving a behavioural 16-deep sync_fifo
module tb_sync_fifo_wr_arb;
    localparam int NUM_REQ = 4;
    localparam int W       = 8;
    localparam int DEPTH   = 16;

    logic                 fifo_clk  = 1'b0;
    logic                 fifo_rstb = 1'b0;
    logic [NUM_REQ-1:0]   wr_req    = '0;
    logic [NUM_REQ*W-1:0] wr_data   = '0;
    logic [NUM_REQ-1:0]   wr_ack;
    logic                 fifo_full = 1'b0;
    logic                 fifo_wren;
    logic [W-1:0]         fifo_wrdata;
    logic                 arb_busy;
    logic [1:0]           arb_owner;
    logic                 fifo_rd   = 1'b0;

    logic [W-1:0] fifo_q [$];
    logic [W-1:0] rd_q [$];
    logic [W-1:0] exp_q [$];
    logic [W-1:0] sq [NUM_REQ][$];
    int n_chk = 0;
    int n_fail = 0;
    int wr_full_err = 0;

    always #5 fifo_clk = ~fifo_clk;

    sync_fifo_wr_arb #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(W), .MAX_BURST(4)) dut (
        .fifo_clk   (fifo_clk),
        .fifo_rstb  (fifo_rstb),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .fifo_full  (fifo_full),
        .fifo_wren  (fifo_wren),
        .fifo_wrdata(fifo_wrdata),
        .arb_busy   (arb_busy),
        .arb_owner  (arb_owner)
    );

    // sync_fifo stand-in: registered full flag, read data lands in rd_q
    always @(posedge fifo_clk or negedge fifo_rstb) begin
        if (!fifo_rstb) begin
            fifo_q.delete();
            fifo_full <= 1'b0;
        end else begin
            if (fifo_rd && fifo_q.size() > 0) rd_q.push_back(fifo_q.pop_front());
            if (fifo_wren) begin
                if (fifo_full) wr_full_err <= wr_full_err + 1;
                else fifo_q.push_back(fifo_wrdata);
            end
            fifo_full <= (fifo_q.size() == DEPTH);
        end
    end

    task automatic set_data(input int i, input logic [W-1:0] d);
        wr_data[i*W +: W] = d;
    endtask

    task automatic do_reset();
        fifo_rstb = 1'b0;
        wr_req    = '0;
        fifo_rd   = 1'b0;
        repeat (2) @(negedge fifo_clk);
        fifo_rstb = 1'b1;
        rd_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        fifo_rstb = 1'b0;
        wr_req    = '0;
        wr_data   = 32'h3C2B1A5D;
        @(negedge fifo_clk);
        n_chk++; if (fifo_wren !== 1'b0) begin n_fail++; $display("FAIL reset_wren: got %b want 0", fifo_wren); end
        n_chk++; if (wr_ack !== 4'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0000", wr_ack); end
        n_chk++; if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", arb_busy); end
        n_chk++; if (arb_owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", arb_owner); end
        n_chk++; if (fifo_wrdata !== 8'h5D) begin n_fail++; $display("FAIL reset_wrdata: got %h want 5d", fifo_wrdata); end
        fifo_rstb = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge fifo_clk);
            n_chk++;
            if (fifo_wren !== 1'b0 || arb_busy !== 1'b0 || wr_ack !== 4'b0) begin
                n_fail++; $display("FAIL idle_quiet: wren=%b busy=%b ack=%b want 0/0/0000", fifo_wren, arb_busy, wr_ack);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_ack;
        logic [W-1:0] d;
        do_reset();
        fifo_rd = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, W'(8'hA0 + i));
        for (int p = 0; p < NUM_REQ; p++) for (int b = 0; b < 4; b++) exp_q.push_back(W'(8'hA0 + p));
        wr_req = '1;
        for (int k = 0; k < 20; k++) begin
            @(negedge fifo_clk);
            exp_ack = (k % 5 != 4) ? NUM_REQ'(1 << (k / 5)) : '0;
            n_chk++; if (wr_ack !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d]: got %b want %b", k, wr_ack, exp_ack); end
            n_chk++; if (fifo_wren !== (|exp_ack)) begin n_fail++; $display("FAIL rr_wren[%0d]: got %b want %b", k, fifo_wren, |exp_ack); end
            if (k == 19) wr_req = '0;
        end
        repeat (4) @(negedge fifo_clk);
        n_chk++; if (rd_q.size() != 16) begin n_fail++; $display("FAIL rr_count: got %0d want 16", rd_q.size()); end
        while (rd_q.size() > 0 && exp_q.size() > 0) begin
            d = rd_q.pop_front();
            n_chk++; if (d !== exp_q[0]) begin n_fail++; $display("FAIL rr_order: got %h want %h", d, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_full();
        int acks;
        logic ackd;
        do_reset();
        acks = 0;
        set_data(2, 8'h20);
        exp_q.push_back(8'h20);
        wr_req = 4'b0100;
        for (int c = 0; c < 60; c++) begin
            @(negedge fifo_clk);
            n_chk++; if (fifo_wren && fifo_full) begin n_fail++; $display("FAIL full_write: got wren=1 with full=1 want no write"); end
            if (c == 44) begin
                n_chk++; if (acks != 16) begin n_fail++; $display("FAIL full_beats: got %0d want 16", acks); end
                n_chk++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_flag: got %b want 1", fifo_full); end
                n_chk++; if (arb_busy !== 1'b1 || arb_owner !== 2'd2) begin n_fail++; $display("FAIL full_hold: got busy=%b owner=%0d want 1/2", arb_busy, arb_owner); end
                n_chk++; if (wr_ack !== 4'b0) begin n_fail++; $display("FAIL full_stall_ack: got %b want 0000", wr_ack); end
            end
            ackd = wr_ack[2];
            if (ackd) acks++;
            @(posedge fifo_clk);
            #1;
            fifo_rd = (c == 45);
            if (ackd && acks < 20) begin
                set_data(2, W'(8'h20 + acks));
                exp_q.push_back(W'(8'h20 + acks));
            end
        end
        n_chk++; if (acks != 17) begin n_fail++; $display("FAIL full_one_after_read: got %0d want 17", acks); end
        n_chk++; if (rd_q.size() != 1 || rd_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL full_read_data: got %0d reads want 1 read of %h", rd_q.size(), exp_q[0]); end
        wr_req = '0;
    endtask

    task automatic test_drop();
        int acks;
        logic [W-1:0] d;
        do_reset();
        fifo_rd = 1'b1;
        acks = 0;
        set_data(0, 8'h01);
        set_data(1, 8'h11);
        set_data(2, 8'h21);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h12);
        wr_req = 4'b0010;
        for (int c = 0; c < 10 && acks < 2; c++) begin
            @(negedge fifo_clk);
            if (wr_ack[1]) acks++;
            @(posedge fifo_clk);
            #1;
            if (acks == 1) set_data(1, 8'h12);
        end
        n_chk++; if (acks != 2) begin n_fail++; $display("FAIL drop_two_beats: got %0d want 2", acks); end
        wr_req = 4'b0101;
        @(negedge fifo_clk);
        n_chk++; if (fifo_wren !== 1'b0 || wr_ack !== 4'b0) begin n_fail++; $display("FAIL drop_no_write: got wren=%b ack=%b want 0/0000", fifo_wren, wr_ack); end
        @(negedge fifo_clk);
        n_chk++; if (arb_busy !== 1'b0 || arb_owner !== 2'd1) begin n_fail++; $display("FAIL drop_idle: got busy=%b owner=%0d want 0/1", arb_busy, arb_owner); end
        @(negedge fifo_clk);
        n_chk++; if (arb_busy !== 1'b1 || arb_owner !== 2'd2) begin n_fail++; $display("FAIL drop_next: got busy=%b owner=%0d want 1/2", arb_busy, arb_owner); end
        n_chk++; if (wr_ack !== 4'b0100 || fifo_wrdata !== 8'h21) begin n_fail++; $display("FAIL drop_next_beat: got ack=%b data=%h want 0100/21", wr_ack, fifo_wrdata); end
        repeat (3) @(negedge fifo_clk);
        wr_req = '0;
        for (int j = 0; j < 2; j++) begin
            d = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
            n_chk++; if (d !== exp_q[j]) begin n_fail++; $display("FAIL drop_data[%0d]: got %h want %h", j, d, exp_q[j]); end
        end
    endtask

    task automatic test_reset_mid();
        int acks;
        do_reset();
        fifo_rd = 1'b1;
        acks = 0;
        for (int i = 0; i < NUM_REQ; i++) set_data(i, W'(8'hA0 + i));
        wr_req = '1;
        for (int c = 0; c < 10 && acks < 2; c++) begin
            @(negedge fifo_clk);
            if (wr_ack[0]) acks++;
            @(posedge fifo_clk);
            #1;
        end
        n_chk++; if (acks != 2) begin n_fail++; $display("FAIL midrst_beats: got %0d want 2", acks); end
        fifo_rstb = 1'b0;
        #1;
        n_chk++; if (fifo_wren !== 1'b0 || wr_ack !== 4'b0) begin n_fail++; $display("FAIL midrst_write: got wren=%b ack=%b want 0/0000", fifo_wren, wr_ack); end
        n_chk++; if (arb_busy !== 1'b0 || arb_owner !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got busy=%b owner=%0d want 0/0", arb_busy, arb_owner); end
        n_chk++; if (fifo_wrdata !== 8'hA0) begin n_fail++; $display("FAIL midrst_wrdata: got %h want a0", fifo_wrdata); end
        @(negedge fifo_clk);
        fifo_rstb = 1'b1;
        @(negedge fifo_clk);
        n_chk++; if (arb_busy !== 1'b1 || arb_owner !== 2'd0 || wr_ack !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_regrant: got busy=%b owner=%0d ack=%b want 1/0/0001", arb_busy, arb_owner, wr_ack);
        end
        wr_req = '0;
    endtask

    task automatic test_random();
        logic pend [NUM_REQ];
        int seq [NUM_REQ];
        int wt [NUM_REQ];
        int max_wait;
        int id;
        logic [NUM_REQ-1:0] ackd;
        logic [W-1:0] d;
        do_reset();
        max_wait = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i] = 1'b0; seq[i] = 0; wt[i] = 0; sq[i].delete();
        end
        for (int cyc = 0; cyc < 12000; cyc++) begin
            @(negedge fifo_clk);
            n_chk++; if (fifo_wren && fifo_full) begin n_fail++; $display("FAIL rand_write_full: cycle %0d got wren=1 with full=1", cyc); end
            n_chk++; if ($countones(wr_ack) > 1 || (|wr_ack) !== fifo_wren) begin n_fail++; $display("FAIL rand_ack: cycle %0d got ack=%b wren=%b want one-hot matching wren", cyc, wr_ack, fifo_wren); end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (wr_req[i] && arb_busy && arb_owner == 2'(i)) begin
                    if (wt[i] > 0) begin
                        n_chk++; if (wt[i] - 1 > 15) begin n_fail++; $display("FAIL rand_starve: producer %0d waited %0d want <= 15", i, wt[i] - 1); end
                        if (wt[i] - 1 > max_wait) max_wait = wt[i] - 1;
                    end
                    wt[i] = 0;
                end else if (!wr_req[i]) wt[i] = 0;
                else if (!fifo_full) wt[i]++;
            end
            ackd = wr_ack;
            @(posedge fifo_clk);
            #1;
            fifo_rd = (cyc >= 10000) || ($urandom_range(99) < (((cyc / 500) % 2 == 1) ? 20 : 80));
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ackd[i]) pend[i] = 1'b0;
                if (!pend[i] && cyc < 10000 && $urandom_range(99) < 60) begin
                    d = {2'(i), 6'(seq[i])};
                    seq[i]++;
                    set_data(i, d);
                    sq[i].push_back(d);
                    pend[i] = 1'b1;
                end
                wr_req[i] = pend[i];
            end
            while (rd_q.size() > 0) begin
                d = rd_q.pop_front();
                id = int'(d[7:6]);
                n_chk++;
                if (sq[id].size() == 0) begin
                    n_fail++; $display("FAIL rand_dup: got unexpected %h want nothing from producer %0d", d, id);
                end else begin
                    if (d !== sq[id][0]) begin n_fail++; $display("FAIL rand_order: got %h want %h", d, sq[id][0]); end
                    void'(sq[id].pop_front());
                end
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            n_chk++; if (pend[i] || sq[i].size() != 0) begin n_fail++; $display("FAIL rand_loss: producer %0d got %0d beats undelivered want 0", i, sq[i].size()); end
        end
        n_chk++; if (fifo_q.size() != 0 || wr_full_err != 0) begin n_fail++; $display("FAIL rand_drain: got fifo=%0d full_writes=%0d want 0/0", fifo_q.size(), wr_full_err); end
        $display("random: worst grant wait %0d cycles", max_wait);
        wr_req  = '0;
        fifo_rd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_full();
        test_drop();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
